branch_compare_unit: RTL
========================

// Module: branch_compare_unit
// PURPOSE
// - Parametrised, pipelined branch-condition evaluator for the ID/EX branch path of the pipelined MIPS core.
// - Supersedes the fixed 32-bit equality-only comparator.
// - Evaluates one of 8 branch conditions on two register operands over STAGES clock cycles.
// - Honours pipeline stall and flush, and keeps a saturating count of taken branches for performance monitoring.
// PARAMETERS
// - WIDTH   32  operand width in bits; must be even and >= 4.
// - STAGES  1   pipeline depth, 1 or 2. Any other value is a compile-time error.
// - CNT_W   16  width of the taken-branch counter.
// PORTS
// - clk          in   1      single clock; all state updates on the rising edge.
// - reset        in   1      asynchronous, active-high reset.
// - in_valid     in   1      rs_data/rt_data/op qualify a branch this cycle.
// - op           in   3      condition select (encoding below).
// - rs_data      in   WIDTH  operand A.
// - rt_data      in   WIDTH  operand B; ignored for the zero-compare ops.
// - stall        in   1      hold all stages; in_valid is ignored while stall=1.
// - flush        in   1      kill all in-flight branches.
// - out_valid    out  1      taken/eq qualify a result.
// - taken        out  1      condition result.
// - eq           out  1      A==B; provided for all ops.
// - taken_cnt    out  CNT_W  saturating count of retired taken branches.
// BEHAVIOUR
// - op encoding:
//     0 BEQ  A==B
//     1 BNE  A!=B
//     2 BLEZ signed A<=0
//     3 BGTZ signed A>0
//     4 BLTZ A[MSB]
//     5 BGEZ !A[MSB]
//     6 BLTU unsigned A<B
//     7 BLT  signed A<B
// - Signed compare is two's complement over WIDTH bits.
// - Unsigned compare uses a WIDTH+1-bit subtract; no overflow is possible.
// - Reset (async, any time, including mid-operation): all stage valid bits=0, out_valid=0, taken=0, eq=0, taken_cnt=0. Data registers need not reset.
// - STAGES=1
//     * Accept on in_valid & !stall & !flush.
//     * Full compare is computed on the input and registered.
//     * out_valid/taken/eq are visible on the next cycle (latency 1).
// - STAGES=2
//     * Stage 1 registers op plus partial results for each WIDTH/2 half: eq_hi, eq_lo, lt_hi (signed and unsigned), lt_lo (unsigned), A[MSB], A==0.
//     * Stage 2 combines them, e.g. lt = lt_hi | (eq_hi & lt_lo).
//     * Latency 2; throughput 1 per cycle.
// - Stall: every stage, including outputs, holds its value. No new accept. A held result stays valid and unchanged.
// - Flush: clears all stage valid bits, so out_valid=0 next cycle. Flush has priority over stall and over in_valid in the same cycle.
// - taken_cnt increments by 1 on each edge where out_valid & taken & !stall & !flush, so a stalled result is counted exactly once.
//     * Saturates at 2^CNT_W-1; no wrap.
// - Back-to-back valid inputs produce back-to-back results in order. No reordering, no drops except by flush.
// - taken/eq are don't-care-free: both are driven 0 whenever out_valid=0.
// STRUCTURE
// - Shared package branch_pkg holds:
//     * localparams BR_BEQ..BR_BLT (3-bit encodings above).
//     * BR_OP_W=3.
// - One sub-module, half_compare: WIDTH/2 slice producing eq, lt_u and lt_s.
//     * Instanced twice for STAGES=2.
//     * The STAGES=1 path may reuse it combinationally.
// - Stage select via generate on STAGES. The counter is inline.
// TESTING
// - Reset mid-stream: assert reset with 2 branches in flight -> out_valid=0 and taken_cnt=0 immediately (async); first result 1/2 cycles after the next accept.
// - BEQ/BNE: A=32'h4, B=32'h4 -> BEQ taken=1, eq=1. B=32'h204 -> BEQ taken=0, BNE taken=1.
// - Sign-sensitive ops:
//     * BLT A=32'hFFFF_FFFF, B=1 -> taken=1.
//     * BLTU same operands -> taken=0.
//     * BLEZ A=0 -> 1. BGTZ A=32'h8000_0000 -> 0.
//     * STAGES=2 halves boundary: A=32'h0001_0000, B=32'h0000_FFFF, BLTU -> 0.
// - Stall/flush:
//     * 3 back-to-back BEQ-true.
//     * stall 2 cycles while the first is at the output -> out_valid held 1, taken_cnt +1 only once.
//     * stall+flush in the same cycle -> out_valid=0 next cycle, taken_cnt stops at 1.
// - Saturation: CNT_W=4, 20 taken branches -> taken_cnt=15 and stays 15.
// - Random: 10k ops in both STAGES configs vs a behavioural model, with random stall/flush -> zero mismatches, latency exact.

Source files
------------

// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch compare unit:
//   - BR_OP_W and the 3-bit branch condition encodings BR_BEQ..BR_BLT
//   - br_part_t : partial compare results of two WIDTH/2 halves
//   - br_eq / br_taken : combine the half results into the final A==B and
//     the selected branch condition
// ----------------------------------------------------------------------------
package branch_pkg;

    localparam int BR_OP_W = 3;

    localparam logic [BR_OP_W-1:0] BR_BEQ  = 3'd0;
    localparam logic [BR_OP_W-1:0] BR_BNE  = 3'd1;
    localparam logic [BR_OP_W-1:0] BR_BLEZ = 3'd2;
    localparam logic [BR_OP_W-1:0] BR_BGTZ = 3'd3;
    localparam logic [BR_OP_W-1:0] BR_BLTZ = 3'd4;
    localparam logic [BR_OP_W-1:0] BR_BGEZ = 3'd5;
    localparam logic [BR_OP_W-1:0] BR_BLTU = 3'd6;
    localparam logic [BR_OP_W-1:0] BR_BLT  = 3'd7;

    // Partial results of the upper and lower operand halves. Only the upper
    // half needs a signed less-than; the lower half is always compared
    // unsigned because the sign lives in the upper half.
    typedef struct packed {
        logic eq_hi;
        logic eq_lo;
        logic lt_u_hi;
        logic lt_s_hi;
        logic lt_u_lo;
        logic a_msb;
        logic a_zero;
    } br_part_t;

    function automatic logic br_eq(input br_part_t p);
        return p.eq_hi & p.eq_lo;
    endfunction

    function automatic logic br_taken(input logic [BR_OP_W-1:0] op,
                                      input br_part_t           p);
        logic eq;
        logic lt_u;
        logic lt_s;
        logic res;
        eq   = p.eq_hi & p.eq_lo;
        lt_u = p.lt_u_hi | (p.eq_hi & p.lt_u_lo);
        lt_s = p.lt_s_hi | (p.eq_hi & p.lt_u_lo);
        case (op)
            BR_BEQ:  res = eq;
            BR_BNE:  res = ~eq;
            BR_BLEZ: res = p.a_msb | p.a_zero;
            BR_BGTZ: res = ~p.a_msb & ~p.a_zero;
            BR_BLTZ: res = p.a_msb;
            BR_BGEZ: res = ~p.a_msb;
            BR_BLTU: res = lt_u;
            BR_BLT:  res = lt_s;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/half_compare.sv
// ----------------------------------------------------------------------------
// half_compare
// Purely combinational compare of one operand slice.
// Parameters:
//   HW      slice width in bits
// Ports:
//   i_a     slice of operand A
//   i_b     slice of operand B
//   o_eq    i_a == i_b
//   o_lt_u  i_a <  i_b, unsigned
//   o_lt_s  i_a <  i_b, two's complement
// ----------------------------------------------------------------------------
module half_compare #(
    parameter int HW = 16
) (
    input  logic [HW-1:0] i_a,
    input  logic [HW-1:0] i_b,
    output logic          o_eq,
    output logic          o_lt_u,
    output logic          o_lt_s
);

    // One extra bit on the subtract: its top bit is the borrow, i.e. a<b.
    logic [HW:0]          w_diff;
    logic signed [HW-1:0] w_a_s;
    logic signed [HW-1:0] w_b_s;

    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_a_s  = i_a;
    assign w_b_s  = i_b;

    assign o_eq   = (i_a == i_b);
    assign o_lt_u = w_diff[HW];
    assign o_lt_s = (w_a_s < w_b_s);

endmodule

// File: rtl/branch_compare_unit.sv
// ----------------------------------------------------------------------------
// branch_compare_unit
// Pipelined branch-condition evaluator for the ID/EX branch path. Evaluates
// one of 8 conditions on rs_data/rt_data over STAGES (1 or 2) cycles, honours
// stall/flush and keeps a saturating count of retired taken branches.
// Parameters:
//   WIDTH   operand width (even, >= 4)
//   STAGES  pipeline depth, 1 or 2
//   CNT_W   taken-branch counter width
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   op/rs_data/rt_data qualify a branch (ignored while stall)
//   op         condition select (see branch_pkg)
//   rs_data    operand A
//   rt_data    operand B
//   stall      hold every stage including the outputs
//   flush      kill all in-flight branches; beats stall and in_valid
//   out_valid  taken/eq qualify a result
//   taken      condition result, 0 when out_valid=0
//   eq         A==B, 0 when out_valid=0
//   taken_cnt  saturating count of retired taken branches
// ----------------------------------------------------------------------------
module branch_compare_unit
    import branch_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [BR_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    output logic               taken,
    output logic               eq,
    output logic [CNT_W-1:0]   taken_cnt
);

    localparam int HW = WIDTH / 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("branch_compare_unit: WIDTH must be even and >= 4");
    end

    logic w_eq_hi;
    logic w_lt_u_hi;
    logic w_lt_s_hi;
    logic w_eq_lo;
    logic w_lt_u_lo;
    logic w_unused_lt_s_lo;
    br_part_t w_part;

    half_compare #(.HW(HW)) u_hi (
        .i_a    (rs_data[WIDTH-1:HW]),
        .i_b    (rt_data[WIDTH-1:HW]),
        .o_eq   (w_eq_hi),
        .o_lt_u (w_lt_u_hi),
        .o_lt_s (w_lt_s_hi)
    );

    half_compare #(.HW(HW)) u_lo (
        .i_a    (rs_data[HW-1:0]),
        .i_b    (rt_data[HW-1:0]),
        .o_eq   (w_eq_lo),
        .o_lt_u (w_lt_u_lo),
        .o_lt_s (w_unused_lt_s_lo)
    );

    always_comb begin
        w_part         = '0;
        w_part.eq_hi   = w_eq_hi;
        w_part.eq_lo   = w_eq_lo;
        w_part.lt_u_hi = w_lt_u_hi;
        w_part.lt_s_hi = w_lt_s_hi;
        w_part.lt_u_lo = w_lt_u_lo;
        w_part.a_msb   = rs_data[WIDTH-1];
        w_part.a_zero  = ~|rs_data;
    end

    logic r_vld_out;
    logic r_taken_out;
    logic r_eq_out;

    if (STAGES == 1) begin : g_s1
        // ---- input -> output register ----
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld_out   <= 1'b0;
                r_taken_out <= 1'b0;
                r_eq_out    <= 1'b0;
            end else if (flush) begin
                r_vld_out   <= 1'b0;
                r_taken_out <= 1'b0;
                r_eq_out    <= 1'b0;
            end else if (!stall) begin
                r_vld_out   <= in_valid;
                r_taken_out <= in_valid & br_taken(op, w_part);
                r_eq_out    <= in_valid & br_eq(w_part);
            end
        end
    end else if (STAGES == 2) begin : g_s2
        logic               r_vld_p1;
        logic [BR_OP_W-1:0] r_op_p1;
        br_part_t           r_part_p1;

        // ---- stage 1: half-width partial results ----
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld_p1 <= 1'b0;
            end else if (flush) begin
                r_vld_p1 <= 1'b0;
            end else if (!stall) begin
                r_vld_p1 <= in_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (!stall) begin
                r_op_p1   <= op;
                r_part_p1 <= w_part;
            end
        end

        // ---- stage 2: combine halves -> output register ----
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld_out   <= 1'b0;
                r_taken_out <= 1'b0;
                r_eq_out    <= 1'b0;
            end else if (flush) begin
                r_vld_out   <= 1'b0;
                r_taken_out <= 1'b0;
                r_eq_out    <= 1'b0;
            end else if (!stall) begin
                r_vld_out   <= r_vld_p1;
                r_taken_out <= r_vld_p1 & br_taken(r_op_p1, r_part_p1);
                r_eq_out    <= r_vld_p1 & br_eq(r_part_p1);
            end
        end
    end else begin : g_bad_stages
        $error("branch_compare_unit: STAGES must be 1 or 2");
    end

    // A result is counted on the edge it leaves the output, so a result held
    // by stall is counted once; a flushed result is never counted.
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_vld_out && r_taken_out && !stall && !flush
                     && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_vld_out;
    assign taken     = r_taken_out;
    assign eq        = r_eq_out;
    assign taken_cnt = r_cnt;

endmodule
